serial_parity_rx: RTL and testbench

- Serial frame receiver and parity checker: the receiving end of a parity-protected serial link. Upstream, the transmitter builds the parity bit by XOR-reducing the data bits.
- Deserialises start / DATA_W data / parity / stop frames, recomputes parity and flags parity and framing errors.
- Sits behind an external bit-timing strobe generator; no oversampling inside.

---
 rtl/serial_parity_rx_pkg.sv | 27 ++
 rtl/serial_parity_rx_parity_acc.sv | 35 +++
 rtl/serial_parity_rx.sv | 134 +++++++++++++
 tb/tb_serial_parity_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_rx_pkg
// Shared types and constants for the parity-protected serial link. The
// receiver uses them, and so does the matching transmitter.
//   state_t  : receiver frame state (IDLE, DATA, PARITY, STOP, BREAK)
//   PAR_EVEN / PAR_ODD : parity sense selectors
//   cnt_w()  : width of a data-bit counter that can hold 0..data_w
// -----------------------------------------------------------------------------
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // The counter must reach data_w itself after the last data bit without wrapping.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// -----------------------------------------------------------------------------
// parity_acc
// A 1-bit registered XOR accumulator. The serial receiver and the matching
// transmitter both use it.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, clears Q
//   CLR : synchronous clear, clears Q (start of a new frame)
//   EN  : when high, Q <= Q ^ D
//   D   : bit to fold into the running parity
//   Q   : running XOR of every bit accepted since the last clear
// -----------------------------------------------------------------------------
module parity_acc (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  input  logic D,
  output logic Q
);

  // Running parity register. Reset and clear both win over accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= 1'b0;
    end else if (CLR) begin
      Q <= 1'b0;
    end else if (EN) begin
      Q <= Q ^ D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
// Receiving end of a parity-protected serial link. It deserialises frames of
// the form start(0) / DATA_W data bits (LSB first) / parity / stop(1). It
// recomputes the parity and flags parity and framing errors. An external
// strobe generator supplies the bit timing, so there is no oversampling here.
// Ports:
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset
//   BIT_EN : sample strobe, SIN is taken only on edges where BIT_EN=1
//   SIN    : serial line, idle high
//   DOUT   : last received data word, held until the next frame completes
//   DVALID : one-cycle pulse, frame complete
//   PERR   : parity error of the frame flagged by DVALID, held
//   FERR   : framing error (stop bit 0) of that frame, held
//   BUSY   : high while in DATA, PARITY, STOP or BREAK
// -----------------------------------------------------------------------------
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter logic PARITY_ODD = PAR_EVEN
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BIT_EN,
  input  logic              SIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  output logic              PERR,
  output logic              FERR,
  output logic              BUSY
);

  localparam int            CW       = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   shreg;
  logic                start;
  logic                take_data;
  logic                take_par;
  logic                take_stop;
  logic                acc_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Transitions happen only on strobe edges.
  always_comb begin
    state_nxt = state;
    if (BIT_EN) begin
      case (state)
        IDLE:    state_nxt = SIN ? IDLE : DATA;
        DATA:    state_nxt = (cnt == LAST_BIT) ? PARITY : DATA;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = SIN ? IDLE : BREAK;
        // A held-low line is not a start bit. Wait for the line to go back to idle.
        BREAK:   state_nxt = SIN ? IDLE : BREAK;
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Per-state datapath controls, qualified by the strobe.
  always_comb begin
    start     = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    take_stop = 1'b0;
    if (BIT_EN) begin
      case (state)
        IDLE:    start     = ~SIN;
        DATA:    take_data = 1'b1;
        PARITY:  take_par  = 1'b1;
        STOP:    take_stop = 1'b1;
        BREAK:   start     = 1'b0;
        default: start     = 1'b0;
      endcase
    end else begin
      start = 1'b0;
    end
  end

  // Data bits and the parity bit are folded in. A start bit clears the accumulator.
  parity_acc u_parity_acc (
    .CLK (CLK),
    .RST (RST),
    .CLR (start),
    .EN  (take_data | take_par),
    .D   (SIN),
    .Q   (acc_q)
  );

  // Bit counter, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= {CW{1'b0}};
      shreg  <= {DATA_W{1'b0}};
      DOUT   <= {DATA_W{1'b0}};
      DVALID <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      if (start) begin
        cnt <= {CW{1'b0}};
      end else if (take_data) begin
        cnt <= cnt + CW'(1);
        // LSB first: after DATA_W shifts the first bit received reaches bit 0.
        shreg <= {SIN, shreg[DATA_W-1:1]};
      end
      if (take_stop) begin
        DOUT   <= shreg;
        PERR   <= acc_q ^ PARITY_ODD;
        FERR   <= ~SIN;
        DVALID <= 1'b1;
      end
      BUSY <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_rx
// Two receivers, one even and one odd parity, share the same line and strobe.
// Expected frames go into one queue per receiver when they are sent. A monitor
// compares them against each DVALID pulse.
// -----------------------------------------------------------------------------
module tb_serial_parity_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BIT_EN;
  logic       SIN;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int dv_cyc_last = 0;
  int dv_cyc_prev = 0;
  logic dv_prev_e = 1'b0;
  logic dv_prev_o = 1'b0;

  // Entry layout: {data[7:0], perr, ferr}.
  logic [9:0] q_e[$];
  logic [9:0] q_o[$];
  logic [9:0] exp_e, exp_o;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .SIN(SIN),
    .DOUT(dout_e), .DVALID(dv_e), .PERR(perr_e), .FERR(ferr_e), .BUSY(busy_e)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .SIN(SIN),
    .DOUT(dout_o), .DVALID(dv_o), .PERR(perr_o), .FERR(ferr_o), .BUSY(busy_o)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (dv_prev_e) check("dvalid_pulse_even", {31'd0, dv_e}, 32'd0);
    if (dv_prev_o) check("dvalid_pulse_odd", {31'd0, dv_o}, 32'd0);
    if (dv_e === 1'b1) begin
      check("sb_entry_even", {31'd0, (q_e.size() != 0)}, 32'd1);
      if (q_e.size() != 0) begin
        exp_e = q_e.pop_front();
        check("dout_even", {24'd0, dout_e}, {24'd0, exp_e[9:2]});
        check("perr_even", {31'd0, perr_e}, {31'd0, exp_e[1]});
        check("ferr_even", {31'd0, ferr_e}, {31'd0, exp_e[0]});
      end
      dv_cyc_prev = dv_cyc_last;
      dv_cyc_last = cyc;
    end
    if (dv_o === 1'b1) begin
      check("sb_entry_odd", {31'd0, (q_o.size() != 0)}, 32'd1);
      if (q_o.size() != 0) begin
        exp_o = q_o.pop_front();
        check("dout_odd", {24'd0, dout_o}, {24'd0, exp_o[9:2]});
        check("perr_odd", {31'd0, perr_o}, {31'd0, exp_o[1]});
        check("ferr_odd", {31'd0, ferr_o}, {31'd0, exp_o[0]});
      end
    end
    dv_prev_e = (dv_e === 1'b1);
    dv_prev_o = (dv_o === 1'b1);
  end

  // One strobe every 4th cycle.
  task automatic strobe(input logic s);
    @(negedge CLK);
    BIT_EN = 1'b1;
    SIN    = s;
    @(negedge CLK);
    BIT_EN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic push_expected(input logic [7:0] d, input logic p, input logic stp);
    logic x;
    x = (^d) ^ p;
    q_e.push_back({d, (x != 1'b0), ~stp});
    q_o.push_back({d, (x != 1'b1), ~stp});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    push_expected(d, p, stp);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i]);
    strobe(p);
    strobe(stp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout_e"}, {24'd0, dout_e}, 32'd0);
    check({tag, "_flags_e"}, {28'd0, dv_e, perr_e, ferr_e, busy_e}, 32'd0);
    check({tag, "_dout_o"}, {24'd0, dout_o}, 32'd0);
    check({tag, "_flags_o"}, {28'd0, dv_o, perr_o, ferr_o, busy_o}, 32'd0);
  endtask

  initial begin
    logic [21:0] stream;
    RST    = 1'b1;
    BIT_EN = 1'b0;
    SIN    = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_all_zero("reset");

    // Good frame: 0xA5 has four ones, so the even parity bit is 0.
    send_frame(8'hA5, 1'b0, 1'b1);
    check("busy_after_stop", {31'd0, busy_e}, 32'd0);
    check("dout_hold_a5", {24'd0, dout_e}, 32'h0000_00A5);

    // Wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1);
    check("perr_hold", {31'd0, perr_e}, 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1);
    check("perr_cleared", {31'd0, perr_e}, 32'd0);

    // Framing error: the receiver enters BREAK and ignores a held-low line.
    send_frame(8'h0F, 1'b0, 1'b0);
    check("busy_in_break", {31'd0, busy_e}, 32'd1);
    check("ferr_hold", {31'd0, ferr_e}, 32'd1);
    repeat (5) strobe(1'b0);
    check("busy_still_break", {31'd0, busy_e}, 32'd1);
    check("dout_hold_0f", {24'd0, dout_e}, 32'h0000_000F);
    strobe(1'b1);
    check("busy_break_exit", {31'd0, busy_e}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);

    // Zero data word: the odd receiver wants parity 1.
    send_frame(8'h00, 1'b1, 1'b1);
    check("odd_perr_ok", {31'd0, perr_o}, 32'd0);
    send_frame(8'h00, 1'b0, 1'b1);
    check("odd_perr_bad", {31'd0, perr_o}, 32'd1);

    // Reset after 3 data bits discards the partial frame.
    strobe(1'b0);
    repeat (3) strobe(1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("midreset");
    send_frame(8'h55, 1'b0, 1'b1);

    // Continuous strobe with two frames back to back.
    // 0x12 has two ones (parity 0) and 0x34 has three ones (parity 1).
    push_expected(8'h12, 1'b0, 1'b1);
    push_expected(8'h34, 1'b1, 1'b1);
    stream = {1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0};
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      BIT_EN = 1'b1;
      SIN    = stream[i];
    end
    @(negedge CLK);
    BIT_EN = 1'b0;
    SIN    = 1'b1;
    repeat (3) @(negedge CLK);
    check("b2b_spacing", dv_cyc_last - dv_cyc_prev, 32'd11);
    check("b2b_dout", {24'd0, dout_e}, 32'h0000_0034);

    // SIN glitches while the strobe is low must not start a frame.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      SIN = i[0];
    end
    @(negedge CLK);
    SIN = 1'b1;
    repeat (3) strobe(1'b1);
    check("glitch_busy", {31'd0, busy_e}, 32'd0);

    repeat (20) @(negedge CLK);
    check("sb_drained_even", q_e.size(), 32'd0);
    check("sb_drained_odd", q_o.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
